// File: rtl/arb_mux2x1dual.sv
// arb_mux2x1dual: round-robin, burst-limited arbiter driving a registered dual 2:1 mux output stage
module arb_mux2x1dual #(
    parameter int WIDTH     = 2,
    parameter int MAX_BURST = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] d0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d1,
    output logic             ack1,
    output logic [WIDTH-1:0] dout,
    output logic             valid_out,
    input  logic             ready_out,
    output logic             selector
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
    state_t state_q, state_d, win_st;
    logic [CW-1:0] burst_q, burst_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic last_q, last_d, valid_q, valid_d, sel_q, sel_d;
    logic load, win1, win0, any_req;
    assign load = !valid_q || ready_out;
    assign any_req = req0 || req1;
    // requester 1 wins alone, on its unexpired burst, on 0's exhausted burst, or by idle alternation
    assign win1 = req1 && (!req0 || (state_q == GRANT1 ? burst_q < MAXC :
                                     state_q == GRANT0 ? burst_q == MAXC : !last_q));
    assign win0 = req0 && !win1;
    assign ack0 = !reset && load && win0;
    assign ack1 = !reset && load && win1;
    assign win_st = win1 ? GRANT1 : GRANT0;
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        last_d  = last_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        if (load && any_req) begin
            dout_d  = win1 ? d1 : d0;
            valid_d = 1'b1;
            sel_d   = win1;
            state_d = win_st;
            last_d  = win1;
            burst_d = (state_q == win_st) ? (burst_q == MAXC ? burst_q : burst_q + CW'(1)) : CW'(1);
        end else if (load) begin
            valid_d = 1'b0;
            state_d = IDLE;
            burst_d = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            burst_q <= '0;
            last_q  <= 1'b1;
            dout_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            last_q  <= last_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
        end
    end
    assign dout      = dout_q;
    assign valid_out = valid_q;
    assign selector  = sel_q;
endmodule

// File: tb/tb_arb_mux2x1dual.sv
// tb_arb_mux2x1dual: directed checks of reset, grants, burst limit, backpressure and idle fairness
module tb_arb_mux2x1dual;
    logic clk = 1'b0, reset = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0, ready_out = 1'b1;
    logic [1:0] d0 = 2'd0, d1 = 2'd0, dout;
    logic ack0, ack1, valid_out, selector;
    int n_cmp = 0, n_err = 0;
    arb_mux2x1dual #(.WIDTH(2), .MAX_BURST(2)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .d0(d0), .ack0(ack0),
        .req1(req1), .d1(d1), .ack1(ack1),
        .dout(dout), .valid_out(valid_out), .ready_out(ready_out), .selector(selector)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic acks(input string tag, input logic e0, input logic e1);
        #1;
        chk({tag, "_ack0"}, 8'(ack0), 8'(e0));
        chk({tag, "_ack1"}, 8'(ack1), 8'(e1));
    endtask
    task automatic edge_chk(input string tag, input logic [1:0] ed, input logic ev, input logic es);
        @(posedge clk);
        #1;
        chk({tag, "_dout"}, 8'(dout), 8'(ed));
        chk({tag, "_valid"}, 8'(valid_out), 8'(ev));
        chk({tag, "_sel"}, 8'(selector), 8'(es));
    endtask
    initial begin
        logic [1:0] seq [6];
        seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
        // reset held two cycles with a pending request
        req0 = 1'b1; d0 = 2'd2; ready_out = 1'b1;
        acks("rst0", 1'b0, 1'b0);
        edge_chk("rst1", 2'd0, 1'b0, 1'b0);
        acks("rst1", 1'b0, 1'b0);
        edge_chk("rst2", 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        acks("rel", 1'b1, 1'b0);
        // single source then drop
        edge_chk("single", 2'd2, 1'b1, 1'b0);
        req0 = 1'b0;
        acks("drop", 1'b0, 1'b0);
        edge_chk("idle", 2'd2, 1'b0, 1'b0);
        // contention from a fresh reset
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1; d0 = 2'd2; d1 = 2'd1;
        for (int i = 0; i < 6; i++) begin
            acks($sformatf("cont%0d", i), seq[i] == 2'd0, seq[i] == 2'd1);
            edge_chk($sformatf("cont%0d", i), seq[i] == 2'd0 ? 2'd2 : 2'd1, 1'b1, seq[i][0]);
        end
        // backpressure: requester 0 has used its burst, so 1 wins once released
        ready_out = 1'b0;
        for (int i = 0; i < 3; i++) begin
            acks($sformatf("bp%0d", i), 1'b0, 1'b0);
            edge_chk($sformatf("bp%0d", i), 2'd2, 1'b1, 1'b0);
        end
        ready_out = 1'b1;
        acks("bprel", 1'b0, 1'b1);
        edge_chk("bprel", 2'd1, 1'b1, 1'b1);
        // idle fairness: after serving 1, an idle gap hands contention to 0
        req0 = 1'b0; req1 = 1'b0;
        acks("gap", 1'b0, 1'b0);
        edge_chk("gap", 2'd1, 1'b0, 1'b1);
        req0 = 1'b1; req1 = 1'b1;
        acks("fair", 1'b1, 1'b0);
        edge_chk("fair", 2'd2, 1'b1, 1'b0);
        // reset in the middle of a burst
        reset = 1'b1;
        acks("mrst", 1'b0, 1'b0);
        edge_chk("mrst", 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        acks("mrel", 1'b1, 1'b0);
        edge_chk("mrel", 2'd2, 1'b1, 1'b0);
        acks("mrel2", 1'b1, 1'b0);
        edge_chk("mrel2", 2'd2, 1'b1, 1'b0);
        acks("mrel3", 1'b0, 1'b1);
        edge_chk("mrel3", 2'd1, 1'b1, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
